// File: rtl/psc_dac_pkg.sv
// Shared types and helpers for the DAC setpoint sequencer: operating modes,
// sequencer states, unity gain constant and the signed saturation helper.
package psc_dac_pkg;

  typedef enum logic [1:0] {
    OPM_SMOOTH = 2'd0,
    OPM_RAMP   = 2'd1,
    OPM_RSVD   = 2'd2,
    OPM_JUMP   = 2'd3
  } opmode_t;

  typedef enum logic [1:0] {
    ST_HOLD   = 2'd0,
    ST_SMOOTH = 2'd1,
    ST_RAMP   = 2'd2
  } seq_state_t;

  localparam logic [17:0] GAIN_UNITY = 18'h20000;

  // Clamp a sign-extended value to the signed range of a w-bit word.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int unsigned        w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

// File: rtl/ramp_table_ram.sv
// Ramp table storage: simple dual-port RAM, one write port, one read port,
// registered read (data appears the cycle after the address). Never reset.
module ramp_table_ram #(
  parameter int DATA_W = 20,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data_q <= mem[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/dac_setpoint_sequencer.sv
// Per-channel DAC setpoint sequencer: jump / smooth / ramp-table playback followed by
// gain, offset and saturation. Define DAC_SMOOTH_EN to build the rate-limited smooth mode.
module dac_setpoint_sequencer
  import psc_dac_pkg::*;
#(
  parameter int               DAC_W       = 20,
  parameter int               ADDR_W      = 14,
  parameter logic [DAC_W-1:0] SMOOTH_STEP = 20'd16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              tick,
  input  logic [1:0]        opmode,
  input  logic [DAC_W-1:0]  setpt,
  input  logic              setpt_wr,
  input  logic [ADDR_W-1:0] ramplen,
  input  logic [ADDR_W-1:0] rampaddr,
  input  logic [DAC_W-1:0]  rampdata,
  input  logic              rampdata_wr,
  input  logic              ramprun,
  input  logic [17:0]       gain,
  input  logic [DAC_W-1:0]  offset,
  output logic [DAC_W-1:0]  dac_code,
  output logic              dac_valid,
  output logic              ramp_active,
  output logic              ramp_done
);

  localparam int PROD_W = DAC_W + 19;

  if (SMOOTH_STEP == '0) begin : g_step_check
    $error("SMOOTH_STEP must be nonzero");
  end

  seq_state_t              state_q, state_d;
  logic [1:0]              opmode_q;
  logic [1:0]              gap_q, gap_d;
  logic [ADDR_W-1:0]       idx_q, idx_d;
  logic [DAC_W-1:0]        target_q, target_d;
  logic [DAC_W-1:0]        raw_q, raw_d;
  logic                    s1_valid_q, s1_valid_d;
  logic                    s1_from_ram_q, s1_from_ram_d;
  logic                    s1_last_q, s1_last_d;
  logic [DAC_W-1:0]        s1_val_q, s1_val_d;
  logic                    s2_valid_q, s2_valid_d;
  logic                    s2_last_q, s2_last_d;
  logic signed [PROD_W-1:0] prod_q, prod_d;
  logic                    s3_valid_q, s3_valid_d;
  logic                    s3_last_q, s3_last_d;
  logic [DAC_W-1:0]        dac_code_q, dac_code_d;
  logic                    dac_valid_q, dac_valid_d;
  logic                    ramp_active_q, ramp_active_d;
  logic                    ramp_done_q, ramp_done_d;

  opmode_t                 opm;
  logic                    mode_chg, running, start, tick_ok;
  logic [ADDR_W-1:0]       rd_addr;
  logic [ADDR_W:0]         next_idx;
  logic [DAC_W-1:0]        rd_data;
  logic signed [DAC_W-1:0] raw_s, offset_s;
  logic signed [18:0]      gain_s;
  logic signed [PROD_W-1:0] sum;
  logic [DAC_W-1:0]        smooth_val;

  ramp_table_ram #(
    .DATA_W (DAC_W),
    .ADDR_W (ADDR_W)
  ) u_table (
    .clk     (clk),
    .wr_en   (rampdata_wr),
    .wr_addr (rampaddr),
    .wr_data (rampdata),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

`ifdef DAC_SMOOTH_EN
  logic signed [DAC_W:0] diff;
  logic signed [DAC_W:0] step_s;

  // raw_q is settled when the next tick arrives (ticks are >= 4 cycles apart).
  always_comb begin
    diff   = $signed({target_q[DAC_W-1], target_q}) - $signed({raw_q[DAC_W-1], raw_q});
    step_s = $signed({1'b0, SMOOTH_STEP});
    if (diff > step_s) begin
      smooth_val = raw_q + SMOOTH_STEP;
    end else if (diff < -step_s) begin
      smooth_val = raw_q - SMOOTH_STEP;
    end else begin
      smooth_val = target_q;
    end
  end
`else
  assign smooth_val = target_q;
`endif

  // Tick acceptance, mode decisions and table addressing (stage 0).
  always_comb begin
    opm           = opmode_t'(opmode);
    mode_chg      = (opmode != opmode_q);
    running       = (state_q == ST_RAMP) && !mode_chg;
    start         = ramprun && (ramplen != '0) && (opm == OPM_RAMP);
    tick_ok       = tick && (gap_q == 2'd0);
    rd_addr       = start ? '0 : idx_q;
    next_idx      = {1'b0, rd_addr} + {{ADDR_W{1'b0}}, 1'b1};

    state_d       = state_q;
    idx_d         = idx_q;
    target_d      = setpt_wr ? setpt : target_q;
    gap_d         = tick_ok ? 2'd3 : ((gap_q != 2'd0) ? gap_q - 2'd1 : 2'd0);
    s1_valid_d    = tick_ok;
    s1_from_ram_d = 1'b0;
    s1_last_d     = 1'b0;
    s1_val_d      = raw_q;

    if (mode_chg && (state_q != ST_HOLD)) begin
      state_d = ST_HOLD;
    end
    if (start) begin
      state_d = ST_RAMP;
      idx_d   = '0;
    end

    if (tick_ok) begin
      if (start || running) begin
        s1_from_ram_d = 1'b1;
        idx_d         = next_idx[ADDR_W-1:0];
        if (next_idx >= {1'b0, ramplen}) begin
          s1_last_d = 1'b1;
          state_d   = ST_HOLD;
        end else begin
          state_d   = ST_RAMP;
        end
      end else begin
        unique case (opm)
          OPM_JUMP: begin
            s1_val_d = target_q;
            state_d  = ST_HOLD;
          end
          OPM_SMOOTH: begin
            s1_val_d = smooth_val;
            state_d  = (smooth_val == target_q) ? ST_HOLD : ST_SMOOTH;
          end
          default: begin
            s1_val_d = raw_q;
            state_d  = ST_HOLD;
          end
        endcase
      end
    end
  end

  // Raw update, multiply, then offset add and saturation (stages 1..3).
  always_comb begin
    raw_s      = $signed(raw_q);
    gain_s     = $signed({1'b0, gain});
    offset_s   = $signed(offset);
    raw_d      = s1_valid_q ? (s1_from_ram_q ? rd_data : s1_val_q) : raw_q;
    s2_valid_d = s1_valid_q;
    s2_last_d  = s1_valid_q && s1_last_q;
    prod_d     = s2_valid_q ? PROD_W'(raw_s) * PROD_W'(gain_s) : prod_q;
    s3_valid_d = s2_valid_q;
    s3_last_d  = s2_valid_q && s2_last_q;
    sum        = (prod_q >>> 17) + PROD_W'(offset_s);
    dac_code_d = s3_valid_q ? DAC_W'(saturate(64'(sum), DAC_W)) : dac_code_q;
    dac_valid_d = s3_valid_q;
    ramp_done_d = s3_valid_q && s3_last_q;

    ramp_active_d = ramp_active_q;
    if (ramp_done_d || ((state_q == ST_RAMP) && mode_chg)) begin
      ramp_active_d = 1'b0;
    end
    if (start) begin
      ramp_active_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_HOLD;
      opmode_q      <= '0;
      gap_q         <= '0;
      idx_q         <= '0;
      target_q      <= '0;
      raw_q         <= '0;
      s1_valid_q    <= 1'b0;
      s1_from_ram_q <= 1'b0;
      s1_last_q     <= 1'b0;
      s1_val_q      <= '0;
      s2_valid_q    <= 1'b0;
      s2_last_q     <= 1'b0;
      prod_q        <= '0;
      s3_valid_q    <= 1'b0;
      s3_last_q     <= 1'b0;
      dac_code_q    <= '0;
      dac_valid_q   <= 1'b0;
      ramp_active_q <= 1'b0;
      ramp_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      opmode_q      <= opmode;
      gap_q         <= gap_d;
      idx_q         <= idx_d;
      target_q      <= target_d;
      raw_q         <= raw_d;
      s1_valid_q    <= s1_valid_d;
      s1_from_ram_q <= s1_from_ram_d;
      s1_last_q     <= s1_last_d;
      s1_val_q      <= s1_val_d;
      s2_valid_q    <= s2_valid_d;
      s2_last_q     <= s2_last_d;
      prod_q        <= prod_d;
      s3_valid_q    <= s3_valid_d;
      s3_last_q     <= s3_last_d;
      dac_code_q    <= dac_code_d;
      dac_valid_q   <= dac_valid_d;
      ramp_active_q <= ramp_active_d;
      ramp_done_q   <= ramp_done_d;
    end
  end

  assign dac_code    = dac_code_q;
  assign dac_valid   = dac_valid_q;
  assign ramp_active = ramp_active_q;
  assign ramp_done   = ramp_done_q;

endmodule

// File: tb/tb_dac_setpoint_sequencer.sv
// Directed bench for dac_setpoint_sequencer: jump, smooth, ramp playback, abort,
// calibration/saturation, tick spacing and asynchronous reset, with hand-computed codes.
module tb_dac_setpoint_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        tick;
  logic [1:0]  opmode;
  logic [19:0] setpt;
  logic        setpt_wr;
  logic [13:0] ramplen;
  logic [13:0] rampaddr;
  logic [19:0] rampdata;
  logic        rampdata_wr;
  logic        ramprun;
  logic [17:0] gain;
  logic [19:0] offset;
  logic [19:0] dac_code;
  logic        dac_valid;
  logic        ramp_active;
  logic        ramp_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dac_setpoint_sequencer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .tick        (tick),
    .opmode      (opmode),
    .setpt       (setpt),
    .setpt_wr    (setpt_wr),
    .ramplen     (ramplen),
    .rampaddr    (rampaddr),
    .rampdata    (rampdata),
    .rampdata_wr (rampdata_wr),
    .ramprun     (ramprun),
    .gain        (gain),
    .offset      (offset),
    .dac_code    (dac_code),
    .dac_valid   (dac_valid),
    .ramp_active (ramp_active),
    .ramp_done   (ramp_done)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_target(input logic [19:0] v);
    setpt    = v;
    setpt_wr = 1'b1;
    step();
    setpt_wr = 1'b0;
  endtask

  // One tick (plus whatever pulses the caller left asserted), then wait for dac_valid.
  task automatic do_tick(input string tag, input logic [19:0] exp_code, input logic exp_done);
    int lat;
    tick = 1'b1;
    step();
    tick     = 1'b0;
    setpt_wr = 1'b0;
    ramprun  = 1'b0;
    lat = 0;
    while (lat < 6 && dac_valid !== 1'b1) begin
      step();
      lat++;
    end
    check_val({tag, "_lat"}, lat, 3);
    check_val({tag, "_code"}, dac_code, exp_code);
    check_val({tag, "_done"}, ramp_done, exp_done);
    step();
    check_val({tag, "_vpulse"}, dac_valid, 0);
    $display("tick %s: code=0x%05h done=%0b active=%0b", tag, dac_code, ramp_done, ramp_active);
  endtask

  initial begin
    int nv;
    reset_n = 1'b0; tick = 1'b0; opmode = 2'd0; setpt = '0; setpt_wr = 1'b0;
    ramplen = '0; rampaddr = '0; rampdata = '0; rampdata_wr = 1'b0; ramprun = 1'b0;
    gain = 18'h20000; offset = '0;
    repeat (3) step();
    check_val("rst_code", dac_code, 0);
    check_val("rst_valid", dac_valid, 0);
    check_val("rst_active", ramp_active, 0);
    check_val("rst_done", ramp_done, 0);
    reset_n = 1'b1;
    step();

    // Smooth from raw=0 toward 40.
    opmode = 2'd0;
    write_target(20'd40);
`ifdef DAC_SMOOTH_EN
    do_tick("smooth1", 20'd16, 1'b0);
    do_tick("smooth2", 20'd32, 1'b0);
    do_tick("smooth3", 20'd40, 1'b0);
    do_tick("smooth4", 20'd40, 1'b0);
`else
    do_tick("smooth1", 20'd40, 1'b0);
    do_tick("smooth2", 20'd40, 1'b0);
`endif

    // Jump with unity gain and offset 0x20.
    opmode = 2'd3;
    offset = 20'h00020;
    write_target(20'h01234);
    do_tick("jump", 20'h01254, 1'b0);

    // Half gain, positive and negative.
    gain = 18'h10000;
    do_tick("half_pos", 20'h0093A, 1'b0);
    write_target(20'hFFF00);
    do_tick("half_neg", 20'hFFFA0, 1'b0);

    // Saturation at both rails.
    gain = 18'h3FFFF;
    write_target(20'h7FFFF);
    do_tick("sat_hi", 20'h7FFFF, 1'b0);
    write_target(20'h80000);
    do_tick("sat_lo", 20'h80000, 1'b0);

    // Tick closer than 4 cycles is dropped.
    gain = 18'h20000;
    offset = '0;
    write_target(20'h00055);
    tick = 1'b1; step(); tick = 1'b0; step();
    tick = 1'b1; step(); tick = 1'b0;
    nv = 0;
    for (int k = 0; k < 10; k++) begin
      if (dac_valid === 1'b1) nv++;
      step();
    end
    check_val("drop_count", nv, 1);
    check_val("drop_code", dac_code, 20'h00055);

    // Setpoint write in the same cycle as a tick uses the old target.
    setpt = 20'h00077;
    setpt_wr = 1'b1;
    do_tick("wr_same", 20'h00055, 1'b0);
    do_tick("wr_next", 20'h00077, 1'b0);

    // Table load, then full ramp playback.
    for (int i = 0; i <= 20; i++) begin
      rampaddr = 14'(i);
      rampdata = 20'(i + 10);
      rampdata_wr = 1'b1;
      step();
    end
    rampdata_wr = 1'b0;
    ramplen = 14'd10;
    opmode = 2'd1;
    step();
    check_val("ramp_idle", ramp_active, 0);
    ramprun = 1'b1;
    step();
    ramprun = 1'b0;
    check_val("ramp_act_rise", ramp_active, 1);
    for (int i = 0; i < 12; i++) begin
      do_tick($sformatf("ramp%0d", i), (i < 10) ? 20'(i + 10) : 20'd19, (i == 9));
      check_val($sformatf("ramp%0d_act", i), ramp_active, (i < 9) ? 1 : 0);
    end

    // Restart with ramprun on the tick, abort after 4 entries.
    ramprun = 1'b1;
    do_tick("abort0", 20'd10, 1'b0);
    do_tick("abort1", 20'd11, 1'b0);
    do_tick("abort2", 20'd12, 1'b0);
    do_tick("abort3", 20'd13, 1'b0);
    check_val("abort_act_pre", ramp_active, 1);
    opmode = 2'd3;
    step();
    check_val("abort_act", ramp_active, 0);
    check_val("abort_hold", dac_code, 20'd13);
    write_target(20'h01000);
    do_tick("abort_jump", 20'h01000, 1'b0);

    // Reset in the middle of a ramp, then replay the retained table.
    opmode = 2'd1;
    step();
    ramprun = 1'b1;
    do_tick("pre_rst0", 20'd10, 1'b0);
    do_tick("pre_rst1", 20'd11, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("mid_rst_code", dac_code, 0);
    check_val("mid_rst_valid", dac_valid, 0);
    check_val("mid_rst_active", ramp_active, 0);
    check_val("mid_rst_done", ramp_done, 0);
    step();
    reset_n = 1'b1;
    step();
    ramprun = 1'b1;
    do_tick("replay0", 20'd10, 1'b0);
    check_val("replay_act", ramp_active, 1);
    do_tick("replay1", 20'd11, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
